// File: rtl/booth_pkg.sv
// Shared types and widths for the Booth multiplier host sequencer.
package booth_pkg;
  localparam int OPW   = 8;
  localparam int PRODW = 16;

  typedef enum logic [2:0] {IDLE, START, LOAD, WAIT, CAP, OUT} state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } operand_t;
endpackage

// File: rtl/booth_operand_buf.sv
// One-entry operand-pair buffer; load only when empty, pop only when full.
module booth_operand_buf
  import booth_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           pop,
  input  logic [OPW-1:0] a_in,
  input  logic [OPW-1:0] b_in,
  output logic           full,
  output logic [OPW-1:0] a_out,
  output logic [OPW-1:0] b_out
);
  logic     full_q, full_d;
  operand_t data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = '{a: a_in, b: b_in};
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full  = full_q;
  assign a_out = data_q.a;
  assign b_out = data_q.b;
endmodule

// File: rtl/booth_sequencer.sv
// Drives the sequential Booth multiplier: loads a then b on the shared bus,
// waits for done, captures the high/low result bytes and hands back the product.
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int M_SLOT   = 1,
  parameter int HI_DELAY = 1,
  parameter int LO_DELAY = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PRODW-1:0] out_product,
  output logic             out_err,
  output logic             mul_enable,
  output logic [OPW-1:0]   mul_inbus,
  input  logic             mul_done,
  input  logic [OPW-1:0]   mul_outbus
);
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam int DW   = $clog2(LO_DELAY + 1);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  operand_t        job_q, job_d;
  logic [OPW-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic            err_q, err_d;

  logic           buf_full, buf_load, buf_pop, go;
  logic [OPW-1:0] buf_a, buf_b;

  // ready drops combinationally with rst_n so nothing is accepted while held in reset
  assign in_ready = rst_n & ~buf_full;
  assign buf_load = in_valid & in_ready;
  assign buf_pop  = go;

  booth_operand_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .pop   (buf_pop),
    .a_in  (in_a),
    .b_in  (in_b),
    .full  (buf_full),
    .a_out (buf_a),
    .b_out (buf_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      job_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      job_q   <= job_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    job_d   = job_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    go      = 1'b0;
    case (state_q)
      IDLE:  go = buf_full;
      START: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q >= CNTW'(M_SLOT)) state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // the done-sample cycle is done-relative 0, so CAP opens at 1
        if (mul_done) begin
          dcnt_d  = DW'(1);
          state_d = CAP;
        end else if (cnt_q == CNTW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = OUT;
        end
      end
      CAP: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DW'(HI_DELAY)) hi_d = mul_outbus;
        if (dcnt_q == DW'(LO_DELAY)) begin
          lo_d    = mul_outbus;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          go      = buf_full;
        end
      end
      default: state_d = IDLE;
    endcase
    // job launch frees the buffer and clears per-job state; hi/lo stay 0 on timeout
    if (go) begin
      state_d = START;
      job_d   = '{a: buf_a, b: buf_b};
      cnt_d   = '0;
      dcnt_d  = '0;
      hi_d    = '0;
      lo_d    = '0;
      err_d   = 1'b0;
    end
  end

  always_comb begin
    mul_enable  = 1'b0;
    mul_inbus   = '0;
    out_valid   = 1'b0;
    out_err     = 1'b0;
    out_product = '0;
    case (state_q)
      START: begin
        mul_enable = 1'b1;
        mul_inbus  = job_q.a;
      end
      LOAD, WAIT: mul_inbus = (cnt_q <= CNTW'(M_SLOT)) ? job_q.a : job_q.b;
      OUT: begin
        out_valid   = 1'b1;
        out_err     = err_q;
        out_product = {hi_q, lo_q};
      end
      default: ;
    endcase
  end
endmodule
